div_arbiter: RTL and testbench

Shares one iterative 32-bit unsigned divider between several measurement requesters in the oscilloscope datapath, e.g. frequency, period and duty-cycle calculators. Each requester raises a request with its operands. A round-robin arbiter grants the divider to one requester, runs a bit-serial restoring division, and returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse addressed to the granted requester.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_arbiter_if.sv | 31 +++
 rtl/div_seq.sv | 112 +++++++++++
 rtl/div_arbiter.sv | 81 ++++++++
 tb/tb_div_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the shared divider arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_N_REQ = 4;

  // Width of the iteration counter, able to hold 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Requester-side bundle of the shared divider: request levels, operands, grant/done and results.
// Latency: none (wires only).
// Backpressure: requesters hold req and operands until their done pulse.
interface div_arbiter_if
  import div_pkg::*;
#(
  parameter int N_REQ = DIV_N_REQ,
  parameter int WIDTH = DIV_WIDTH
) ();

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [WIDTH-1:0]       q;
  logic [WIDTH-1:0]       r;
  logic                   dz;

  modport master (
    output req, a_in, b_in,
    input  gnt, done, busy, q, r, dz
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, done, busy, q, r, dz
  );

endinterface

// File: rtl/div_seq.sv
// Bit-serial restoring unsigned divider with IDLE/CALC/DONE sequencing.
// Latency: WIDTH cycles of CALC then one DONE cycle; divide-by-zero skips straight to DONE.
// Backpressure: start is only honoured in IDLE; busy stays high until DONE exits.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b_r;
  // {rem, quot}: rem carries one extra bit because a shifted remainder can reach 2*b-1.
  logic [2*WIDTH:0] rq;
  logic [2*WIDTH:0] rq_sh;
  logic [2*WIDTH:0] rq_step;
  logic [WIDTH:0]   rem_sh;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));

  // One restoring step: shift, then subtract the divisor when it fits.
  always_comb begin
    rq_sh   = rq << 1;
    rem_sh  = rq_sh[2*WIDTH:WIDTH];
    rq_step = rq_sh;
    if (rem_sh >= {1'b0, b_r}) begin
      rq_step[2*WIDTH:WIDTH] = rem_sh - {1'b0, b_r};
      rq_step[0]             = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (b == '0) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        fin       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers; results only change on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      b_r <= '0;
      rq  <= '0;
      q   <= '0;
      r   <= '0;
      dz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rq  <= {{(WIDTH+1){1'b0}}, a};
            b_r <= b;
            cnt <= '0;
            if (b == '0) begin
              q  <= '1;
              r  <= a;
              dz <= 1'b1;
            end
          end
        end
        CALC: begin
          rq  <= rq_step;
          cnt <= cnt + CW'(1);
          if (last) begin
            q  <= rq_step[WIDTH-1:0];
            r  <= rq_step[2*WIDTH-1:WIDTH];
            dz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sharing of one iterative divider between N_REQ requesters.
// Latency: accept to done is WIDTH+1 cycles (1 cycle for divide-by-zero); next accept one cycle after DONE.
// Backpressure: requests wait on their req level while the divider is busy; no queueing.
module div_arbiter
  import div_pkg::*;
#(
  parameter int N_REQ = DIV_N_REQ,
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  div_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic [PW-1:0]    win_nxt;
  logic             found;
  logic             start;
  logic             seq_busy;
  logic             seq_fin;
  logic [N_REQ-1:0] gnt_r;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] seq_q;
  logic [WIDTH-1:0] seq_r;
  logic             seq_dz;

  // Round-robin pick: first asserted req at or after ptr, wrapping.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req[(int'(ptr) + i) % N_REQ]) begin
        win   = PW'((int'(ptr) + i) % N_REQ);
        found = 1'b1;
      end
    end
  end

  assign win_nxt = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
  assign start   = found & ~seq_busy;
  assign a_sel   = bus.a_in[int'(win)*WIDTH +: WIDTH];
  assign b_sel   = bus.b_in[int'(win)*WIDTH +: WIDTH];

  // Grant is held from accept through DONE; ptr advances past each winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_r <= '0;
      ptr   <= '0;
    end else if (start) begin
      gnt_r <= N_REQ'(1) << win;
      ptr   <= win_nxt;
    end else if (seq_fin) begin
      gnt_r <= '0;
    end
  end

  div_seq #(.WIDTH(WIDTH)) u_seq (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_sel),
    .b     (b_sel),
    .busy  (seq_busy),
    .fin   (seq_fin),
    .q     (seq_q),
    .r     (seq_r),
    .dz    (seq_dz)
  );

  assign bus.gnt  = gnt_r;
  assign bus.done = seq_fin ? gnt_r : '0;
  assign bus.busy = seq_busy;
  assign bus.q    = seq_q;
  assign bus.r    = seq_r;
  assign bus.dz   = seq_dz;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed scenarios plus random traffic against a cycle-level reference.
// Latency: model predicts accept, DONE entry and results from the arbitration and division rules.
// Backpressure: requesters hold req/operands until their done, then drop or re-request.
module tb_div_arbiter;
  import div_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]   req_v  = '0;
  logic [N*W-1:0] a_flat = '0;
  logic [N*W-1:0] b_flat = '0;

  always #5 clk = ~clk;

  div_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  assign bus.req  = req_v;
  assign bus.a_in = a_flat;
  assign bus.b_in = b_flat;

  div_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference: phase 0 idle, 1 dividing, 2 results presented.
  int         m_ph   = 0;
  int         m_own  = -1;
  int         m_left = 0;
  int         m_ptr  = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_q = '0, m_r = '0;
  logic         m_dz = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the reference by one rising edge using the inputs the DUT just sampled.
  function automatic void model_edge();
    int w;
    if (rst) begin
      m_ph = 0; m_own = -1; m_ptr = 0;
      m_q = '0; m_r = '0; m_dz = 1'b0;
    end else if (m_ph == 2) begin
      m_ph = 0; m_own = -1;
    end else if (m_ph == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_ph = 2; m_q = m_a / m_b; m_r = m_a % m_b; m_dz = 1'b0;
      end
    end else if (req_v != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req_v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      m_own = w;
      m_ptr = (w + 1) % N;
      m_a = a_flat[w*W +: W];
      m_b = b_flat[w*W +: W];
      if (m_b == '0) begin
        m_ph = 2; m_q = '1; m_r = m_a; m_dz = 1'b1;
      end else begin
        m_ph = 1; m_left = W;
      end
    end
  endfunction

  task automatic compare_all();
    logic [N-1:0] eg;
    logic [N-1:0] ed;
    eg = '0;
    if (m_own >= 0) eg[m_own] = 1'b1;
    ed = (m_ph == 2) ? eg : '0;
    chk("gnt",  bus.gnt,  eg);
    chk("done", bus.done, ed);
    chk("busy", bus.busy, m_ph != 0);
    chk("q",    bus.q,    m_q);
    chk("r",    bus.r,    m_r);
    chk("dz",   bus.dz,   m_dz);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_flat[i*W +: W] = a;
    b_flat[i*W +: W] = b;
    req_v[i] = 1'b1;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return W'($urandom_range(0, 15));
      4:       return 32'h8000_0000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic wait_gnt(input int idx);
    logic [N-1:0] oh;
    bit seen;
    oh = '0; oh[idx] = 1'b1; seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      tick();
      if (bus.gnt != '0) begin
        seen = 1;
        chk("accept_gnt", bus.gnt, oh);
      end
    end
    if (!seen) chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_done(input int idx, input logic [W-1:0] eq, input logic [W-1:0] er);
    bit seen;
    seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      tick();
      if (bus.done[idx]) begin
        seen = 1;
        chk("res_q", bus.q, eq);
        chk("res_r", bus.r, er);
        req_v[idx] = 1'b0;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  // Single request from idle; latency counts the cycle after the accepting edge as 1.
  task automatic run_one(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    int  acc;
    bit  seen;
    logic [N-1:0] oh;
    oh = '0; oh[idx] = 1'b1; acc = -1; seen = 0;
    set_op(idx, a, b);
    for (int t = 0; t < 100 && !seen; t++) begin
      tick();
      if (acc < 0 && bus.gnt != '0) begin
        acc = t;
        chk("accept_gnt", bus.gnt, oh);
      end
      if (bus.done != '0) begin
        seen = 1;
        chk("latency", t - acc + 1, (b == '0) ? 1 : W + 1);
        chk("done_idx", bus.done, oh);
        chk("res_q", bus.q, eq);
        chk("res_r", bus.r, er);
        chk("res_dz", bus.dz, edz);
        req_v[idx] = 1'b0;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, last, idx;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_q", bus.q, 0);
    rst = 1'b0;
    tick();

    // Single request and boundary operands.
    run_one(0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_one(0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_one(0, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b0);
    run_one(0, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0);

    // Divide by zero, then a normal divide clears dz.
    run_one(0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
    run_one(0, 32'd10, 32'd3, 32'd3, 32'd1, 1'b0);

    // Fairness from a freshly reset pointer with all requests held.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom) | 32'd1);
    k = 0; last = 0;
    for (int t = 0; t < 400 && k < 8; t++) begin
      tick();
      if (bus.done != '0) begin
        idx = -1;
        for (int i = 0; i < N; i++) if (bus.done[i]) idx = i;
        chk("rr_order", idx, k % N);
        if (k > 0) chk("rr_gap", t - last, W + 2);
        last = t;
        k++;
      end
    end
    chk("rr_count", k, 8);
    req_v = '0;
    tick();
    tick();

    // Reset mid-operation: no done, outputs cleared, pointer back to 0.
    set_op(2, 32'd999, 32'd4);
    wait_gnt(2);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("midrst_gnt", bus.gnt, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_q", bus.q, 0);
    rst = 1'b0;
    req_v[2] = 1'b0;
    set_op(1, 32'd50, 32'd6);
    set_op(3, 32'd81, 32'd9);
    wait_gnt(1);
    wait_done(1, 32'd8, 32'd2);
    wait_done(3, 32'd9, 32'd0);

    // Request drop: requester 2 wins from ptr=2, drops mid-op, still completes; 1 follows.
    run_one(1, 32'd10, 32'd3, 32'd3, 32'd1, 1'b0);
    set_op(2, 32'd1000, 32'd9);
    set_op(1, 32'd77, 32'd10);
    wait_gnt(2);
    repeat (5) tick();
    req_v[2] = 1'b0;
    wait_done(2, 32'd111, 32'd1);
    tick();
    chk("drop_idle_gnt", bus.gnt, 0);
    tick();
    chk("drop_next_gnt", bus.gnt, 4'b0010);
    wait_done(1, 32'd7, 32'd7);
    tick();
    tick();

    // Random traffic, occasional mid-op drops and resets.
    for (int t = 0; t < 3000; t++) begin
      tick();
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < N; i++) begin
        if (m_ph == 2 && m_own == i) begin
          if ($urandom_range(0, 1) == 0) req_v[i] = 1'b0;
          else set_op(i, rnd_op(), rnd_op());
        end else if (!req_v[i]) begin
          if ($urandom_range(0, 3) == 0) set_op(i, rnd_op(), rnd_op());
        end else if (m_own == i && m_ph == 1 && $urandom_range(0, 49) == 0) begin
          req_v[i] = 1'b0;
        end
      end
    end
    rst = 1'b0;
    req_v = '0;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
